// File: rtl/seg_scan_decoder.sv
// Reads back a scanned, active-low 7-segment display bus and decodes each digit's settled
// glyph into a hex nibble, with per-digit valid/error flags and a frame-complete pulse.
module seg_scan_decoder #(
    parameter int NUM_DIGITS    = 6,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_DIGITS-1:0]     seg_sel,
    input  logic [6:0]                seg_data,
    input  logic                      clear,
    output logic [4*NUM_DIGITS-1:0]   hex_data,
    output logic [NUM_DIGITS-1:0]     digit_valid,
    output logic [NUM_DIGITS-1:0]     pattern_err,
    output logic                      frame_done
);

    localparam int                    CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]      CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]      CNT_ONE = CNT_W'(1);
    localparam logic [NUM_DIGITS-1:0] ONE_D   = NUM_DIGITS'(1);
    localparam logic [NUM_DIGITS-1:0] ALL_D   = {NUM_DIGITS{1'b1}};

    typedef enum logic [1:0] {IDLE, TRACK, HELD} state_t;

    logic [NUM_DIGITS-1:0]   sel_s1_q, sel_s2_q, prev_sel_q;
    logic [6:0]              dat_s1_q, dat_s2_q, prev_dat_q;
    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] hex_q, hex_d;
    logic [NUM_DIGITS-1:0]   valid_q, valid_d;
    logic [NUM_DIGITS-1:0]   err_q, err_d;
    logic [NUM_DIGITS-1:0]   mask_q, mask_d;
    logic                    frame_q, frame_d;

    logic [NUM_DIGITS-1:0]   slot_oh;
    logic                    slot_ok;
    logic                    same;
    logic                    capture;
    logic [4:0]              glyph;

    // Returns {legal, nibble}; legal=0 for blank and for any unknown pattern.
    function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
        case (seg)
            7'h40:   decode_glyph = 5'h10;
            7'h79:   decode_glyph = 5'h11;
            7'h24:   decode_glyph = 5'h12;
            7'h30:   decode_glyph = 5'h13;
            7'h19:   decode_glyph = 5'h14;
            7'h12:   decode_glyph = 5'h15;
            7'h02:   decode_glyph = 5'h16;
            7'h78:   decode_glyph = 5'h17;
            7'h00:   decode_glyph = 5'h18;
            7'h10:   decode_glyph = 5'h19;
            7'h08:   decode_glyph = 5'h1A;
            7'h03:   decode_glyph = 5'h1B;
            7'h46:   decode_glyph = 5'h1C;
            7'h21:   decode_glyph = 5'h1D;
            7'h06:   decode_glyph = 5'h1E;
            7'h0E:   decode_glyph = 5'h1F;
            default: decode_glyph = 5'h00;
        endcase
    endfunction

    always_comb begin
        slot_oh = ~sel_s2_q;
        slot_ok = (slot_oh != '0) && ((slot_oh & (slot_oh - ONE_D)) == '0);
        same    = (sel_s2_q == prev_sel_q) && (dat_s2_q == prev_dat_q);
        glyph   = decode_glyph(dat_s2_q);
    end

    // Settle tracker: one capture per run of STABLE_CYCLES identical synced samples.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (slot_ok) begin
                    state_d = TRACK;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            TRACK: begin
                if (!slot_ok) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (!same) begin
                    cnt_d   = CNT_ONE;
                end else if (cnt_q + CNT_ONE >= CNT_MAX) begin
                    cnt_d   = CNT_MAX;
                    capture = 1'b1;
                    state_d = HELD;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            HELD: begin
                if (!slot_ok) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (!same) begin
                    state_d = TRACK;
                    cnt_d   = CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        hex_d   = hex_q;
        valid_d = valid_q;
        err_d   = err_q;
        mask_d  = mask_q;
        frame_d = 1'b0;
        if (mask_q == ALL_D) begin
            frame_d = 1'b1;
            mask_d  = '0;
        end
        if (capture) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (slot_oh[i]) begin
                    mask_d[i] = 1'b1;
                    if (glyph[4]) begin
                        hex_d[4*i +: 4] = glyph[3:0];
                        valid_d[i]      = 1'b1;
                        err_d[i]        = 1'b0;
                    end else begin
                        valid_d[i]      = 1'b0;
                        err_d[i]        = (dat_s2_q != 7'h7F);
                    end
                end
            end
        end
        if (clear) begin
            hex_d   = '0;
            valid_d = '0;
            err_d   = '0;
            mask_d  = '0;
            frame_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_s1_q   <= '1;
            sel_s2_q   <= '1;
            dat_s1_q   <= '1;
            dat_s2_q   <= '1;
            prev_sel_q <= '1;
            prev_dat_q <= '1;
            state_q    <= IDLE;
            cnt_q      <= '0;
            hex_q      <= '0;
            valid_q    <= '0;
            err_q      <= '0;
            mask_q     <= '0;
            frame_q    <= 1'b0;
        end else begin
            sel_s1_q   <= seg_sel;
            sel_s2_q   <= sel_s1_q;
            dat_s1_q   <= seg_data;
            dat_s2_q   <= dat_s1_q;
            prev_sel_q <= sel_s2_q;
            prev_dat_q <= dat_s2_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hex_q      <= hex_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            mask_q     <= mask_d;
            frame_q    <= frame_d;
        end
    end

    assign hex_data    = hex_q;
    assign digit_valid = valid_q;
    assign pattern_err = err_q;
    assign frame_done  = frame_q;

endmodule
